sprite_addr_gen: RTL and testbench

Per-pixel sprite address generator and compositor that sits directly upstream of the 128×128×12-bit sprite sheet ROM (14-bit address, registered read with 1-cycle latency when enabled). It compares incoming VGA pixel coordinates against a 2× scaled 16×16 sprite window and forms the sheet address of the current animation tile, optionally mirrored. It then aligns the returned ROM word with a delayed hit flag and emits RGB plus a pixel-hit qualifier, with the transparency key removed. Sprite attributes are latched once per frame, and a frame-rate animation counter selects the tile.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_anim_ctrl.sv | 59 +++++
 rtl/sprite_addr_gen.sv | 97 +++++++++
 tb/tb_sprite_addr_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: sheet geometry, colour key and the per-frame sprite attribute bundle
package sprite_pkg;
  localparam int SHEET_ADDR_W = 14;
  localparam int RGB_W = 12;
  localparam int TILE_PX = 16;
  localparam int SHEET_TILES_ROW = 8;
  localparam int SCALE_SHIFT = 1;
  localparam int COORD_W = 16;
  localparam logic [RGB_W-1:0] TRANSPARENT_KEY = 12'hF0F;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               flip_h;
    logic [5:0]         tile_base;
    logic [1:0]         anim_len;
  } sprite_attr_t;
endpackage

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: per-frame attribute latch, arming flag and frame-rate animation tile selection
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int ANIM_DIV = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start_i,
  input  logic               anim_run_i,
  input  sprite_attr_t       attr_i,
  output logic [COORD_W-1:0] sx_o,
  output logic [COORD_W-1:0] sy_o,
  output logic               flip_o,
  output logic               armed_o,
  output logic [5:0]         tile_o
);
  localparam int DIV_W = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  sprite_attr_t     attr_q;
  logic             armed_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  // idx >= len (not ==) so a shrunken animation length wraps on the next step
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (frame_start_i) begin
      if (!anim_run_i) begin
        div_d = '0;
        idx_d = '0;
      end else if (div_q == DIV_W'(ANIM_DIV - 1)) begin
        div_d = '0;
        idx_d = idx_q >= attr_q.anim_len ? 2'd0 : idx_q + 2'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      attr_q  <= '0;
      armed_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
    end else begin
      if (frame_start_i) begin
        attr_q  <= attr_i;
        armed_q <= 1'b1;
      end
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end
  assign sx_o    = attr_q.x;
  assign sy_o    = attr_q.y;
  assign flip_o  = attr_q.flip_h;
  assign armed_o = armed_q;
  assign tile_o  = attr_q.tile_base + {4'd0, idx_q};
endmodule

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: 2x scaled sprite window hit test, sheet ROM address pipeline and
// colour-keyed compositor; fixed 3-clock latency from pixel strobe to rgb_out.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int               H_BITS      = 10,
  parameter int               V_BITS      = 10,
  parameter int               ANIM_DIV    = 8,
  parameter logic [RGB_W-1:0] TRANSPARENT = TRANSPARENT_KEY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pix_en,
  input  logic [H_BITS-1:0]       h_cnt,
  input  logic [V_BITS-1:0]       v_cnt,
  input  logic                    frame_start,
  input  logic [H_BITS-1:0]       sprite_x,
  input  logic [V_BITS-1:0]       sprite_y,
  input  logic                    flip_h,
  input  logic [5:0]              tile_base,
  input  logic [1:0]              anim_len,
  input  logic                    anim_run,
  output logic                    rom_en,
  output logic [SHEET_ADDR_W-1:0] rom_addr,
  input  logic [RGB_W-1:0]        rom_data,
  output logic [RGB_W-1:0]        rgb_out,
  output logic                    pix_hit,
  output logic                    out_valid
);
  localparam int WIN = TILE_PX << SCALE_SHIFT;
  sprite_attr_t              attr_in;
  logic [COORD_W-1:0]        sx, sy;
  logic                      flip, armed, hit, rom_en_d, pix_hit_d;
  logic [5:0]                tile;
  logic [H_BITS-1:0]         dx;
  logic [V_BITS-1:0]         dy;
  logic [3:0]                lx, ly;
  logic [SHEET_ADDR_W-1:0]   addr_d;
  logic                      rom_en_q, v1_q, v2_q, h2_q, out_valid_q, pix_hit_q;
  logic [SHEET_ADDR_W-1:0]   rom_addr_q;
  logic [RGB_W-1:0]          rgb_q;

  assign attr_in = '{x: COORD_W'(sprite_x), y: COORD_W'(sprite_y), flip_h: flip_h,
                     tile_base: tile_base, anim_len: anim_len};

  sprite_anim_ctrl #(.ANIM_DIV(ANIM_DIV)) u_anim (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start),
    .anim_run_i    (anim_run),
    .attr_i        (attr_in),
    .sx_o          (sx),
    .sy_o          (sy),
    .flip_o        (flip),
    .armed_o       (armed),
    .tile_o        (tile)
  );

  // The >= guards reject pixels left/above the sprite whose wrapped difference looks small
  assign dx        = h_cnt - sx[H_BITS-1:0];
  assign dy        = v_cnt - sy[V_BITS-1:0];
  assign hit       = armed && COORD_W'(h_cnt) >= sx && dx < H_BITS'(WIN)
                           && COORD_W'(v_cnt) >= sy && dy < V_BITS'(WIN);
  assign lx        = flip ? 4'd15 - dx[SCALE_SHIFT +: 4] : dx[SCALE_SHIFT +: 4];
  assign ly        = dy[SCALE_SHIFT +: 4];
  assign addr_d    = {tile[5:3], ly, tile[2:0], lx};
  assign rom_en_d  = pix_en && hit;
  assign pix_hit_d = h2_q && rom_data != TRANSPARENT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      h2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      pix_hit_q   <= 1'b0;
      rgb_q       <= '0;
    end else begin
      rom_en_q    <= rom_en_d;
      if (rom_en_d) rom_addr_q <= addr_d;
      v1_q        <= pix_en;
      v2_q        <= v1_q;
      h2_q        <= rom_en_q;
      out_valid_q <= v2_q;
      pix_hit_q   <= pix_hit_d;
      rgb_q       <= pix_hit_d ? rom_data : '0;
    end
  end

  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign rgb_out   = rgb_q;
  assign pix_hit   = pix_hit_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_sprite_addr_gen.sv
// tb_sprite_addr_gen: directed tests of sprite_addr_gen with a 1-cycle registered ROM model
module tb_sprite_addr_gen;
  logic        clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0, frame_start = 1'b0;
  logic        flip_h = 1'b0, anim_run = 1'b0;
  logic [9:0]  h_cnt = '0, v_cnt = '0, sprite_x = '0, sprite_y = '0;
  logic [5:0]  tile_base = '0;
  logic [1:0]  anim_len = '0;
  logic        rom_en, pix_hit, out_valid;
  logic [13:0] rom_addr;
  logic [11:0] rom_data = '0, rgb_out;
  logic        rom_by_addr = 1'b0;
  logic [11:0] rom_val = '0;
  int          checks = 0, failures = 0;

  sprite_addr_gen #(.H_BITS(10), .V_BITS(10), .ANIM_DIV(2), .TRANSPARENT(12'hF0F)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .frame_start(frame_start), .sprite_x(sprite_x), .sprite_y(sprite_y), .flip_h(flip_h),
    .tile_base(tile_base), .anim_len(anim_len), .anim_run(anim_run), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .rgb_out(rgb_out), .pix_hit(pix_hit),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_en) rom_data <= rom_by_addr ? rom_addr[11:0] : rom_val;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v, output logic en,
                     output logic [13:0] a, output logic val, output logic hit,
                     output logic [11:0] rgb);
    h_cnt = h;
    v_cnt = v;
    pix_en = 1'b1;
    step();
    pix_en = 1'b0;
    en = rom_en;
    a = rom_addr;
    step();
    step();
    val = out_valid;
    hit = pix_hit;
    rgb = rgb_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (rom_en !== 1'b0) begin failures++; $display("FAIL reset_rom_en got=%b exp=0", rom_en); end
    checks++; if (rom_addr !== 14'h0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
    checks++; if (rgb_out !== 12'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=0", rgb_out); end
    checks++; if (pix_hit !== 1'b0) begin failures++; $display("FAIL reset_pix_hit got=%b exp=0", pix_hit); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 103; i++) begin
      pix_en = (i < 100);
      h_cnt = 10'(i);
      v_cnt = 10'(i % 7);
      step();
      checks++; if (rom_en !== 1'b0) begin failures++; $display("FAIL unarmed_rom_en i=%0d got=%b exp=0", i, rom_en); end
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'(i < 102) || pix_hit !== 1'b0 || rgb_out !== 12'h0) begin
          failures++;
          $display("FAIL unarmed_out i=%0d got v=%b h=%b rgb=%h exp v=%b h=0 rgb=0", i, out_valid, pix_hit, rgb_out, i < 102);
        end
      end
    end
    pix_en = 1'b0;
  endtask

  task automatic test_address();
    logic en, val, hit;
    logic [13:0] a;
    logic [11:0] rgb;
    sprite_x = 10'd100; sprite_y = 10'd50; tile_base = 6'd9; flip_h = 1'b0;
    anim_len = 2'd0; anim_run = 1'b0;
    frame();
    rom_by_addr = 1'b0; rom_val = 12'h0F0;
    pix(10'd103, 10'd53, en, a, val, hit, rgb);
    checks++; if (en !== 1'b1) begin failures++; $display("FAIL addr_rom_en got=%b exp=1", en); end
    checks++; if (a !== 14'h0891) begin failures++; $display("FAIL addr_value got=%h exp=0891", a); end
    checks++; if (val !== 1'b1) begin failures++; $display("FAIL addr_out_valid got=%b exp=1", val); end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL addr_pix_hit got=%b exp=1", hit); end
    checks++; if (rgb !== 12'h0F0) begin failures++; $display("FAIL addr_rgb got=%h exp=0f0", rgb); end
  endtask

  task automatic test_flip_edges();
    logic en, val, hit;
    logic [13:0] a;
    logic [11:0] rgb;
    logic [9:0] hs [3] = '{10'd132, 10'd99, 10'd100};
    logic [9:0] vs [3] = '{10'd50, 10'd50, 10'd82};
    flip_h = 1'b1;
    frame();
    pix(10'd100, 10'd50, en, a, val, hit, rgb);
    checks++; if (en !== 1'b1 || a !== 14'h081F) begin failures++; $display("FAIL flip_origin got en=%b a=%h exp en=1 a=081f", en, a); end
    pix(10'd131, 10'd81, en, a, val, hit, rgb);
    checks++; if (a !== 14'h0F90) begin failures++; $display("FAIL flip_corner_addr got=%h exp=0f90", a); end
    checks++; if (hit !== 1'b1 || rgb !== 12'h0F0) begin failures++; $display("FAIL flip_corner_hit got h=%b rgb=%h exp h=1 rgb=0f0", hit, rgb); end
    for (int k = 0; k < 3; k++) begin
      pix(hs[k], vs[k], en, a, val, hit, rgb);
      checks++;
      if (en !== 1'b0 || hit !== 1'b0 || val !== 1'b1 || a !== 14'h0F90) begin
        failures++;
        $display("FAIL edge_miss (%0d,%0d) got en=%b h=%b v=%b a=%h exp en=0 h=0 v=1 a=0f90", hs[k], vs[k], en, hit, val, a);
      end
    end
  endtask

  task automatic test_transparency();
    logic en, val, hit;
    logic [13:0] a;
    logic [11:0] rgb;
    rom_val = 12'hF0F;
    pix(10'd110, 10'd60, en, a, val, hit, rgb);
    checks++; if (en !== 1'b1 || a !== 14'h0A9A) begin failures++; $display("FAIL key_read got en=%b a=%h exp en=1 a=0a9a", en, a); end
    checks++; if (val !== 1'b1) begin failures++; $display("FAIL key_out_valid got=%b exp=1", val); end
    checks++; if (hit !== 1'b0 || rgb !== 12'h0) begin failures++; $display("FAIL key_pixel got h=%b rgb=%h exp h=0 rgb=0", hit, rgb); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  hs [3]     = '{10'd100, 10'd302, 10'd200};
    logic        exp_en [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [13:0] exp_a [2]  = '{14'h0810, 14'h0811};
    logic        exp_h [3]  = '{1'b1, 1'b1, 1'b0};
    logic [11:0] exp_c [3]  = '{12'h810, 12'h811, 12'h000};
    flip_h = 1'b0;
    frame();
    rom_by_addr = 1'b1;
    sprite_x = 10'd300;
    v_cnt = 10'd50;
    for (int k = 0; k < 5; k++) begin
      pix_en = (k < 3);
      frame_start = (k == 0);
      if (k < 3) h_cnt = hs[k];
      step();
      checks++; if (rom_en !== exp_en[k]) begin failures++; $display("FAIL b2b_rom_en k=%0d got=%b exp=%b", k, rom_en, exp_en[k]); end
      if (k < 2) begin
        checks++; if (rom_addr !== exp_a[k]) begin failures++; $display("FAIL b2b_addr k=%0d got=%h exp=%h", k, rom_addr, exp_a[k]); end
      end
      if (k >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || pix_hit !== exp_h[k-2] || rgb_out !== exp_c[k-2]) begin
          failures++;
          $display("FAIL b2b_out k=%0d got v=%b h=%b rgb=%h exp v=1 h=%b rgb=%h", k, out_valid, pix_hit, rgb_out, exp_h[k-2], exp_c[k-2]);
        end
      end
    end
    pix_en = 1'b0;
    frame_start = 1'b0;
    sprite_x = 10'd100;
    rom_by_addr = 1'b0;
  endtask

  task automatic test_anim();
    logic en, val, hit;
    logic [13:0] a, ea;
    logic [11:0] rgb;
    logic [5:0] t;
    int exp_tile [8] = '{63, 0, 0, 1, 1, 63, 63, 0};
    sprite_x = 10'd100; sprite_y = 10'd50; flip_h = 1'b0;
    tile_base = 6'd63; anim_len = 2'd2; anim_run = 1'b0;
    frame();
    pix(10'd100, 10'd50, en, a, val, hit, rgb);
    checks++; if (a !== 14'h3870) begin failures++; $display("FAIL anim_start got=%h exp=3870", a); end
    anim_run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      frame();
      pix(10'd100, 10'd50, en, a, val, hit, rgb);
      t = 6'(exp_tile[i]);
      ea = {t[5:3], 4'b0000, t[2:0], 4'b0000};
      checks++; if (a !== ea) begin failures++; $display("FAIL anim_frame%0d got=%h exp=%h (tile %0d)", i + 1, a, ea, exp_tile[i]); end
    end
    anim_run = 1'b0;
    frame();
    pix(10'd100, 10'd50, en, a, val, hit, rgb);
    checks++; if (a !== 14'h3870) begin failures++; $display("FAIL anim_stop got=%h exp=3870", a); end
  endtask

  task automatic test_reset_mid();
    logic en, val, hit;
    logic [13:0] a;
    logic [11:0] rgb;
    rom_val = 12'h123;
    h_cnt = 10'd100;
    v_cnt = 10'd50;
    pix_en = 1'b1;
    repeat (4) step();
    checks++; if (out_valid !== 1'b1 || pix_hit !== 1'b1 || rom_en !== 1'b1) begin failures++; $display("FAIL mid_pre got v=%b h=%b en=%b exp 1 1 1", out_valid, pix_hit, rom_en); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rom_en !== 1'b0 || rom_addr !== 14'h0 || rgb_out !== 12'h0 || pix_hit !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got en=%b a=%h rgb=%h h=%b v=%b exp all 0", rom_en, rom_addr, rgb_out, pix_hit, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (rom_en !== 1'b0) begin failures++; $display("FAIL mid_disarmed_en k=%0d got=%b exp=0", k, rom_en); end
      checks++;
      if (out_valid !== 1'(k >= 2) || pix_hit !== 1'b0) begin
        failures++;
        $display("FAIL mid_disarmed_out k=%0d got v=%b h=%b exp v=%b h=0", k, out_valid, pix_hit, k >= 2);
      end
    end
    pix_en = 1'b0;
    frame();
    pix(10'd100, 10'd50, en, a, val, hit, rgb);
    checks++; if (en !== 1'b1 || hit !== 1'b1 || rgb !== 12'h123) begin failures++; $display("FAIL mid_rearm got en=%b h=%b rgb=%h exp 1 1 123", en, hit, rgb); end
  endtask

  initial begin
    test_reset();
    test_address();
    test_flip_edges();
    test_transparency();
    test_back_to_back();
    test_anim();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
